// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse cipher core: S-box tables, Rcon,
// FSM state encoding, block type and GF(2^8) helpers.
package aes_pkg;

    typedef logic [127:0] block_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEXP,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } state_t;

    // Element 0 is the leftmost byte of each row.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // RCON[i] is the constant for round key i (1..10); other slots unused.
    localparam logic [0:15][7:0] RCON = 128'h0001020408102040801b360000000000;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_inv_core_if.sv
// Load/data/result bundle of the AES-128 inverse cipher core.
interface aes_inv_core_if;
    import aes_pkg::*;

    logic   load;
    block_t key;
    block_t cyphertext;
    logic   done;
    block_t plaintext;

    modport master (output load, output key, output cyphertext,
                    input  done, input  plaintext);
    modport slave  (input  load, input  key, input  cyphertext,
                    output done, output plaintext);

endinterface

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless i_bypass_mix selects the final-round form.
module aes_inv_round
    import aes_pkg::*;
(
    input  block_t i_state,
    input  block_t i_rkey,
    input  logic   i_bypass_mix,
    output block_t o_state
);

    logic [7:0] w_ark [16];
    logic [7:0] w_mix [16];

    // Byte b = 4*col + row; InvShiftRows moves row r right by r columns.
    always_comb begin
        for (int unsigned b = 0; b < 16; b++) begin
            int unsigned row;
            int unsigned col;
            int unsigned src;
            row = b % 4;
            col = b / 4;
            src = 4 * ((col + 4 - row) % 4) + row;
            w_ark[b] = INV_SBOX[i_state[127 - 8 * src -: 8]] ^ i_rkey[127 - 8 * b -: 8];
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < 4; c++) begin
            logic [7:0] a0, a1, a2, a3;
            a0 = w_ark[4 * c];
            a1 = w_ark[4 * c + 1];
            a2 = w_ark[4 * c + 2];
            a3 = w_ark[4 * c + 3];
            w_mix[4 * c]     = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            w_mix[4 * c + 1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            w_mix[4 * c + 2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            w_mix[4 * c + 3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
    end

    always_comb begin
        o_state = '0;
        for (int unsigned b = 0; b < 16; b++) begin
            o_state[127 - 8 * b -: 8] = i_bypass_mix ? w_ark[b] : w_mix[b];
        end
    end

endmodule

// File: rtl/aes_inv_core.sv
// AES-128 decryption core: forward key expansion, then ten inverse rounds with
// on-the-fly inverse key schedule. Optional AES_INV_KEYCACHE_EN caches rk10.
module aes_inv_core
    import aes_pkg::*;
(
    input  logic           clk,
    input  logic           nreset,
    aes_inv_core_if.slave  bus
);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_armed;
    block_t     r_key_in;
    block_t     r_ct_in;
    block_t     r_key;
    block_t     r_data;
    block_t     r_pt;
    logic       r_done;

    block_t     w_key_fwd;
    block_t     w_key_inv;
    block_t     w_round_out;
    logic       w_final;

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
    endfunction

    function automatic block_t key_fwd(input block_t k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h000000};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo key_fwd: recover the last three words first, then word 0.
    function automatic block_t key_inv(input block_t k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h000000};
        return {w0, w1, w2, w3};
    endfunction

    // In ROUND/FINAL r_cnt names the key being produced, so the Rcon is that of r_cnt+1.
    assign w_key_fwd = key_fwd(r_key, RCON[r_cnt]);
    assign w_key_inv = key_inv(r_key, RCON[r_cnt + 4'd1]);
    assign w_final   = (r_state == ST_FINAL);

    aes_inv_round u_round (
        .i_state      (r_data),
        .i_rkey       (w_key_inv),
        .i_bypass_mix (w_final),
        .o_state      (w_round_out)
    );

`ifdef AES_INV_KEYCACHE_EN
    block_t r_cache_key;
    block_t r_cache_rk10;
    logic   r_cache_vld;
    logic   w_hit;

    assign w_hit = r_cache_vld && (r_cache_key == r_key_in);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cache_key  <= '0;
            r_cache_rk10 <= '0;
            r_cache_vld  <= 1'b0;
        end else if (!bus.load && r_state == ST_KEXP && r_cnt == 4'd10) begin
            r_cache_key  <= r_key_in;
            r_cache_rk10 <= w_key_fwd;
            r_cache_vld  <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_armed  <= 1'b0;
            r_key_in <= '0;
            r_ct_in  <= '0;
            r_key    <= '0;
            r_data   <= '0;
            r_pt     <= '0;
            r_done   <= 1'b0;
        end else if (bus.load) begin
            r_key_in <= bus.key;
            r_ct_in  <= bus.cyphertext;
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_armed  <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_armed) begin
                        r_armed <= 1'b0;
`ifdef AES_INV_KEYCACHE_EN
                        if (w_hit) begin
                            r_key   <= r_cache_rk10;
                            r_data  <= r_ct_in ^ r_cache_rk10;
                            r_cnt   <= 4'd9;
                            r_state <= ST_ROUND;
                        end else begin
                            r_key   <= r_key_in;
                            r_cnt   <= 4'd1;
                            r_state <= ST_KEXP;
                        end
`else
                        r_key   <= r_key_in;
                        r_cnt   <= 4'd1;
                        r_state <= ST_KEXP;
`endif
                    end
                end
                ST_KEXP: begin
                    r_key <= w_key_fwd;
                    if (r_cnt == 4'd10) begin
                        r_data  <= r_ct_in ^ w_key_fwd;
                        r_cnt   <= 4'd9;
                        r_state <= ST_ROUND;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_ROUND: begin
                    r_key  <= w_key_inv;
                    r_data <= w_round_out;
                    if (r_cnt == 4'd1) begin
                        r_cnt   <= '0;
                        r_state <= ST_FINAL;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_FINAL: begin
                    r_key   <= w_key_inv;
                    r_data  <= w_round_out;
                    r_pt    <= w_round_out;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.done      = r_done;
    assign bus.plaintext = r_pt;

endmodule

// File: tb/tb_aes_inv_core.sv
// Directed FIPS-197 vectors for aes_inv_core: latency, hold, reset and abort.
module tb_aes_inv_core;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam int FULL_LAT = 20;
`ifdef AES_INV_KEYCACHE_EN
    localparam int HIT_LAT = 10;
`else
    localparam int HIT_LAT = 20;
`endif

    logic clk = 1'b0;
    logic nreset;
    int   n_total = 0;
    int   n_bad   = 0;
    int   lat;

    aes_inv_core_if bus ();

    aes_inv_core dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after a clock edge; returns #1 after the capture edge.
    task automatic load_block(input logic [127:0] k, input logic [127:0] ct);
        bus.load       = 1'b1;
        bus.key        = k;
        bus.cyphertext = ct;
        @(posedge clk);
        #1 bus.load = 1'b0;
    endtask

    // Passes E0, then counts edges until done rises; -1 if it never does.
    task automatic wait_done(output int l);
        l = -1;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                l = n;
                break;
            end
        end
    endtask

    task automatic run_block(input string tag, input logic [127:0] k, input logic [127:0] ct,
                             input logic [127:0] pt, input int exp_lat);
        int l;
        load_block(k, ct);
        check_val({tag, "_load_done"}, 128'(bus.done), 128'd0);
        wait_done(l);
        check_val({tag, "_lat"}, 128'(l), 128'(exp_lat));
        check_val({tag, "_pt"}, bus.plaintext, pt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset         = 1'b0;
        bus.load       = 1'b0;
        bus.key        = '0;
        bus.cyphertext = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_done", 128'(bus.done), 128'd0);
        check_val("rst_pt", bus.plaintext, 128'd0);
        nreset = 1'b1;

        repeat (25) @(posedge clk);
        #1 check_val("idle_noload_done", 128'(bus.done), 128'd0);

        run_block("c1", K1, C1, P1, FULL_LAT);
        repeat (5) @(posedge clk);
        #1;
        check_val("hold_done", 128'(bus.done), 128'd1);
        check_val("hold_pt", bus.plaintext, P1);

        run_block("b", K2, C2, P2, FULL_LAT);

        // Reset after E12 of a C.1 run, which cached K1 at E10 in the cache build.
        load_block(K1, C1);
        @(posedge clk);
        repeat (12) @(posedge clk);
        #1 nreset = 1'b0;
        #1;
        check_val("midrst_done", 128'(bus.done), 128'd0);
        check_val("midrst_pt", bus.plaintext, 128'd0);
        #3 nreset = 1'b1;
        repeat (25) @(posedge clk);
        #1 check_val("midrst_noload_done", 128'(bus.done), 128'd0);
        run_block("c1_rerun", K1, C1, P1, FULL_LAT);

        // Abort a C.1 run with B vectors sampled at E7.
        load_block(K1, C1);
        @(posedge clk);
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1 check_val($sformatf("abort_e%0d_done", e), 128'(bus.done), 128'd0);
        end
        check_val("abort_pt_held", bus.plaintext, P1);
        run_block("abort_b", K2, C2, P2, FULL_LAT);

        // Cache holds K2 here: first C.1 expands, the repeat may hit.
        run_block("cache_c1a", K1, C1, P1, FULL_LAT);
        run_block("cache_c1b", K1, C1, P1, HIT_LAT);
        run_block("cache_b", K2, C2, P2, FULL_LAT);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
